bcd_counter_chain: RTL
======================

// Module: bcd_counter_chain
// PURPOSE
//   Synchronous multi-digit modulo counter (BCD by default) replacing ripple-clocked counters.
//   All digits share one clock. The block adds:
//     - up/down counting, parallel load, synchronous clear
//     - a combinational carry out for cascading instances
//     - a registered wrap flag
//   Used for event counters and display-driving digit counters.
// PARAMETERS
//   DIGITS   4   number of cascaded digits (>=1)
//   DW       4   bits per digit
//   MODULUS  10  count states per digit; 2 <= MODULUS <= 2**DW
// PORTS
//   clk       in   1          single clock; all state changes on rising edge
//   rst       in   1          synchronous, active-high reset
//   en        in   1          count enable; one step per cycle when high
//   up        in   1          1 = count up, 0 = count down
//   clear     in   1          synchronous clear to all-zero
//   load      in   1          parallel load of load_val
//   load_val  in   DIGITS*DW  digit k at bits [k*DW +: DW]; digit 0 is least significant
//   q         out  DIGITS*DW  current count, same digit packing as load_val
//   co        out  1          carry/borrow out for cascading (combinational)
//   wrap      out  1          one-cycle registered pulse on full-chain wrap
//   load_err  out  1          one-cycle registered pulse when a loaded digit was out of range
// BEHAVIOUR
//   - Reset: rst high at a clock edge forces q=0, wrap=0, load_err=0, overriding all other inputs.
//   - Priority, highest first: rst > clear > load > en. Idle otherwise; q holds.
//   - clear: q=0 next cycle; wrap=0, load_err=0.
//   - load: each digit takes its load_val digit on the next edge.
//     - A digit >= MODULUS is loaded as 0.
//     - load_err pulses in the same cycle q updates if any digit was out of range.
//     - wrap=0 on a load cycle.
//   - Count (en=1, no higher-priority input):
//     - Digit 0 always steps.
//     - Digit k>0 steps only when every lower digit is at its terminal value:
//       MODULUS-1 when up=1, 0 when up=0.
//   - Digit step:
//     - up:   d==MODULUS-1 -> 0,          else d+1.
//     - down: d==0         -> MODULUS-1,  else d-1.
//     - Arithmetic is DW wide and never produces a value >= MODULUS.
//   - Latency: q reflects the step one cycle after the enabling edge; no internal pipelining.
//   - co = en & up & all digits==MODULUS-1, OR en & ~up & all digits==0.
//     - co is forced 0 while rst, clear or load is high.
//     - Drive the next instance's en from co to build a longer chain.
//   - wrap: registered; high for exactly the one cycle in which q shows the wrapped value
//     (all-0 after counting up, all MODULUS-1 after counting down).
//   - Direction change: up toggling between cycles takes effect immediately; no extra state.
//   - Reset mid-count: no residual carry or wrap state survives.
//   - en=0 with up toggling: q unchanged and co=0.
// TESTING
//   1. DIGITS=4, MODULUS=10:
//      rst 2 cycles -> q=0x0000, wrap=0, co=0, load_err=0.
//   2. en=1, up=1 from 0x0000 for 10 cycles -> q=0x0009 at cycle 9, q=0x0010 at cycle 10.
//   3. load_val=0x9998, load, then en=1, up=1:
//      - q=0x9998 -> 0x9999, with co=1 during the 0x9999 cycle
//      - then q=0x0000 with wrap=1 for one cycle
//   4. From 0x0000, en=1, up=0 one cycle -> q=0x9999, wrap=1.
//      Next cycle -> q=0x9998, wrap=0.
//   5. load_val=0x12A4, load -> q=0x1204, load_err=1 for one cycle.
//      Then clear and load asserted together -> q=0x0000 (clear wins).
//   6. Count to 0x0057, assert rst for 1 cycle mid-count -> q=0x0000.
//      en still high after reset -> q=0x0001 on the next cycle.

Source files
------------

// File: rtl/bcd_counter_chain_if.sv
// Control/data bundle for one bcd_counter_chain instance.
// The master drives the count controls; the slave returns the count and the status pulses.
interface bcd_counter_chain_if #(
  parameter int DIGITS = 4,
  parameter int DW     = 4
);
  logic                   en;
  logic                   up;
  logic                   clear;
  logic                   load;
  logic [DIGITS*DW-1:0]   load_val;
  logic [DIGITS*DW-1:0]   q;
  logic                   co;
  logic                   wrap;
  logic                   load_err;

  modport master (
    output en, up, clear, load, load_val,
    input  q, co, wrap, load_err
  );

  modport slave (
    input  en, up, clear, load, load_val,
    output q, co, wrap, load_err
  );
endinterface

// File: rtl/bcd_counter_chain.sv
// Synchronous multi-digit modulo counter with up/down, load, clear, cascade carry and wrap flag.
// Every digit shares one clock; a digit steps when all lower digits sit at their terminal value.
module bcd_counter_chain #(
  parameter int DIGITS  = 4,
  parameter int DW      = 4,
  parameter int MODULUS = 10
) (
  input logic               clk,
  input logic               rst,
  bcd_counter_chain_if.slave bus
);
  localparam logic [DW:0]   MOD_X = (DW+1)'(MODULUS);
  localparam logic [DW-1:0] TOP   = DW'(MODULUS - 1);

  logic [DW-1:0]     dig_p0  [DIGITS];
  logic [DW-1:0]     dig_nxt [DIGITS];
  logic [DW-1:0]     ld_dig  [DIGITS];
  logic [DIGITS-1:0] ld_oor;
  logic              all_term;
  logic              cnt_act;
  logic              wrap_p0;
  logic              load_err_p0;

  function automatic logic [DW-1:0] step_digit(input logic [DW-1:0] d, input logic dir_up);
    if (dir_up) return (d == TOP) ? '0 : d + DW'(1);
    else        return (d == '0)  ? TOP : d - DW'(1);
  endfunction

  function automatic logic out_of_range(input logic [DW-1:0] d);
    return {1'b0, d} >= MOD_X;
  endfunction

  // Stage p0 inputs: carry chain across digits and load sanitising.
  always_comb begin
    logic run;
    run = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      dig_nxt[k] = run ? step_digit(dig_p0[k], bus.up) : dig_p0[k];
      run        = run & (dig_p0[k] == (bus.up ? TOP : '0));
      ld_oor[k]  = out_of_range(bus.load_val[k*DW +: DW]);
      ld_dig[k]  = ld_oor[k] ? '0 : bus.load_val[k*DW +: DW];
    end
    all_term = run;
  end

  assign cnt_act = bus.en & ~rst & ~bus.clear & ~bus.load;
  assign bus.co  = cnt_act & all_term;

  // Stage p0 register: digits and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_p0      <= '{default: '0};
      wrap_p0     <= 1'b0;
      load_err_p0 <= 1'b0;
    end else if (bus.clear) begin
      dig_p0      <= '{default: '0};
      wrap_p0     <= 1'b0;
      load_err_p0 <= 1'b0;
    end else if (bus.load) begin
      dig_p0      <= ld_dig;
      wrap_p0     <= 1'b0;
      load_err_p0 <= |ld_oor;
    end else if (bus.en) begin
      dig_p0      <= dig_nxt;
      wrap_p0     <= all_term;
      load_err_p0 <= 1'b0;
    end else begin
      wrap_p0     <= 1'b0;
      load_err_p0 <= 1'b0;
    end
  end

  always_comb begin
    bus.q = '0;
    for (int k = 0; k < DIGITS; k++) begin
      bus.q[k*DW +: DW] = dig_p0[k];
    end
  end

  assign bus.wrap     = wrap_p0;
  assign bus.load_err = load_err_p0;
endmodule
